// File: rtl/match_ctrl_pkg.sv
// Shared definitions for the Pong match controller: FSM state encoding,
// winner codes and default output widths used by ball and display_text.
package match_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_P2   = 2'd2;

   localparam int DEF_SCORE_W = 4;
   localparam int DEF_SEC_W   = 6;
   localparam int DEF_SPEED_W = 4;

endpackage

// File: rtl/match_ctrl_if.sv
// Bus between the match controller and its neighbours.
//   slave  : match_ctrl side (frame/button/goal pulses in, game status out)
//   master : ball / buttons / display side (drives pulses, reads status)
interface match_ctrl_if
   import match_ctrl_pkg::*;
#(
   parameter int SCORE_W = DEF_SCORE_W,
   parameter int SEC_W   = DEF_SEC_W,
   parameter int SPEED_W = DEF_SPEED_W
);
   logic               refresh_tick;
   logic               start_pulse;
   logic               pause_pulse;
   logic               goal_left;
   logic               goal_right;
   state_t             state;
   logic               run;
   logic               ball_serve;
   logic               serve_dir;
   logic [SCORE_W-1:0] score_player1;
   logic [SCORE_W-1:0] score_player2;
   logic [SEC_W-1:0]   seconds;
   logic [SPEED_W-1:0] ball_speed;
   logic [1:0]         winner;

   modport slave (
      input  refresh_tick, start_pulse, pause_pulse, goal_left, goal_right,
      output state, run, ball_serve, serve_dir, score_player1, score_player2,
             seconds, ball_speed, winner
   );

   modport master (
      output refresh_tick, start_pulse, pause_pulse, goal_left, goal_right,
      input  state, run, ball_serve, serve_dir, score_player1, score_player2,
             seconds, ball_speed, winner
   );
endinterface

// File: rtl/match_ctrl_frame_divider.sv
// Divides refresh_tick down to a one-cycle sec_tick every FRAMES_PER_SEC
// frames. Counts only while enable is high; clear restarts the second.
// sec_tick is combinational so the owner can register its effect in the
// cycle right after the frame that completed the second.
//   clk, reset     : clock, synchronous active-high reset
//   refresh_tick   : one pulse per frame
//   enable, clear  : count enable, restart
//   sec_tick       : pulse on the frame that completes a second
module match_ctrl_frame_divider #(
   parameter int FRAMES_PER_SEC = 60
) (
   input  logic clk,
   input  logic reset,
   input  logic refresh_tick,
   input  logic enable,
   input  logic clear,
   output logic sec_tick
);
   localparam int CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(FRAMES_PER_SEC - 1);

   // frames still to go before the second completes
   logic [CNT_W-1:0] remaining;

   assign sec_tick = enable & refresh_tick & (remaining == '0);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         remaining <= LOAD;
      end else if (enable && refresh_tick) begin
         remaining <= (remaining == '0) ? LOAD : remaining - 1'b1;
      end
   end
endmodule

// File: rtl/match_ctrl.sv
// Match/game-flow controller for VGA Pong: owns the game FSM, scores,
// match clock and ball speed. All outputs are registered.
//   clk, reset : clock, synchronous active-high reset
//   bus        : match_ctrl_if.slave (pulses in, status out)
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | after reset, waiting for start
//   SERVE    | ball parked, counting SERVE_FRAMES before launch
//   PLAY     | ball running, match clock and speed-up active
//   PAUSE    | everything frozen until pause toggled again
//   OVER     | a player reached WIN_SCORE, result held
module match_ctrl
   import match_ctrl_pkg::*;
#(
   parameter int FRAMES_PER_SEC = 60,
   parameter int SERVE_FRAMES   = 90,
   parameter int SCORE_W        = DEF_SCORE_W,
   parameter int WIN_SCORE      = 7,
   parameter int SEC_W          = DEF_SEC_W,
   parameter int MAX_SECONDS    = 59,
   parameter int SPEED_W        = DEF_SPEED_W,
   parameter int SPEED_MIN      = 2,
   parameter int SPEED_MAX      = 8,
   parameter int SPEED_STEP_SEC = 10
) (
   input  logic          clk,
   input  logic          reset,
   match_ctrl_if.slave   bus
);
   localparam int SRV_W = $clog2(SERVE_FRAMES + 1);
   localparam int PS_W  = (SPEED_STEP_SEC > 1) ? $clog2(SPEED_STEP_SEC) : 1;

   state_t             state_q, state_d;
   logic               run_q, serve_q, dir_q;
   logic [SCORE_W-1:0] score1_q, score2_q;
   logic [SEC_W-1:0]   seconds_q;
   logic [SPEED_W-1:0] speed_q;
   logic [1:0]         winner_q;
   logic [SRV_W-1:0]   serve_left;
   logic [PS_W-1:0]    play_sec;

   logic goal_any, only_right, only_left, p1_wins, p2_wins;
   logic new_match, launch, point, sec_tick;

   assign goal_any   = bus.goal_left | bus.goal_right;
   assign only_right = bus.goal_right & ~bus.goal_left;
   assign only_left  = bus.goal_left & ~bus.goal_right;
   assign p1_wins    = only_right & (score1_q == SCORE_W'(WIN_SCORE - 1));
   assign p2_wins    = only_left  & (score2_q == SCORE_W'(WIN_SCORE - 1));

   always_comb begin
      state_d   = state_q;
      new_match = 1'b0;
      launch    = 1'b0;
      point     = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (bus.start_pulse) begin
               state_d   = ST_SERVE;
               new_match = 1'b1;
            end
         end
         ST_SERVE: begin
            if (bus.refresh_tick && serve_left == SRV_W'(1)) begin
               state_d = ST_PLAY;
               launch  = 1'b1;
            end
         end
         ST_PLAY: begin
            // a goal outranks a simultaneous pause request
            if (goal_any) begin
               point   = 1'b1;
               state_d = (p1_wins || p2_wins) ? ST_OVER : ST_SERVE;
            end else if (bus.pause_pulse) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (bus.pause_pulse) state_d = ST_PLAY;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // frames stall on a goal cycle so the goal fully owns that frame
   match_ctrl_frame_divider #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_frame_div (
      .clk          (clk),
      .reset        (reset),
      .refresh_tick (bus.refresh_tick),
      .enable       ((state_q == ST_PLAY) & ~goal_any),
      .clear        (new_match),
      .sec_tick     (sec_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_q      <= 1'b0;
         serve_q    <= 1'b0;
         dir_q      <= 1'b0;
         score1_q   <= '0;
         score2_q   <= '0;
         seconds_q  <= '0;
         speed_q    <= SPEED_W'(SPEED_MIN);
         winner_q   <= WIN_NONE;
         serve_left <= '0;
         play_sec   <= '0;
      end else begin
         run_q   <= (state_d == ST_PLAY);
         serve_q <= launch;

         // serve delay runs as a down-counter armed on entry to SERVE
         if (state_d == ST_SERVE && state_q != ST_SERVE) begin
            serve_left <= SRV_W'(SERVE_FRAMES);
         end else if (state_q == ST_SERVE && bus.refresh_tick) begin
            serve_left <= serve_left - 1'b1;
         end

         if (new_match) begin
            score1_q  <= '0;
            score2_q  <= '0;
            seconds_q <= '0;
            winner_q  <= WIN_NONE;
            speed_q   <= SPEED_W'(SPEED_MIN);
            dir_q     <= 1'b0;
            play_sec  <= '0;
         end else if (point) begin
            speed_q  <= SPEED_W'(SPEED_MIN);
            play_sec <= '0;
            // serve goes toward the player who conceded
            if (only_right) begin
               score1_q <= score1_q + 1'b1;
               dir_q    <= 1'b1;
            end
            if (only_left) begin
               score2_q <= score2_q + 1'b1;
               dir_q    <= 1'b0;
            end
            if (p1_wins) winner_q <= WIN_P1;
            if (p2_wins) winner_q <= WIN_P2;
         end else if (sec_tick) begin
            if (seconds_q != SEC_W'(MAX_SECONDS)) seconds_q <= seconds_q + 1'b1;
            if (play_sec == PS_W'(SPEED_STEP_SEC - 1)) begin
               play_sec <= '0;
               if (speed_q != SPEED_W'(SPEED_MAX)) speed_q <= speed_q + 1'b1;
            end else begin
               play_sec <= play_sec + 1'b1;
            end
         end
      end
   end

   assign bus.state         = state_q;
   assign bus.run           = run_q;
   assign bus.ball_serve    = serve_q;
   assign bus.serve_dir     = dir_q;
   assign bus.score_player1 = score1_q;
   assign bus.score_player2 = score2_q;
   assign bus.seconds       = seconds_q;
   assign bus.ball_speed    = speed_q;
   assign bus.winner        = winner_q;
endmodule

// File: tb/tb_match_ctrl.sv
module tb_match_ctrl;
   import match_ctrl_pkg::*;

   localparam int FPS = 4, SRV = 3, WIN = 3, STEP = 2, SMIN = 2, SMAX = 4, MAXS = 59;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   match_ctrl_if #(.SCORE_W(4), .SEC_W(6), .SPEED_W(4)) bus ();

   match_ctrl #(
      .FRAMES_PER_SEC(FPS), .SERVE_FRAMES(SRV), .SCORE_W(4), .WIN_SCORE(WIN),
      .SEC_W(6), .MAX_SECONDS(MAXS), .SPEED_W(4), .SPEED_MIN(SMIN),
      .SPEED_MAX(SMAX), .SPEED_STEP_SEC(STEP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural reference: counts frames/seconds upward the way the rules read
   int m_mode, m_frames, m_serve_cnt, m_play_secs;
   int m_s1, m_s2, m_sec, m_speed, m_winner, m_dir, m_run, m_serve;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = ST_IDLE; m_frames = 0; m_serve_cnt = 0; m_play_secs = 0;
      m_s1 = 0; m_s2 = 0; m_sec = 0; m_speed = SMIN; m_winner = 0;
      m_dir = 0; m_run = 0; m_serve = 0;
   endtask

   task automatic model_step(input logic st, pa, gl, gr, tk);
      m_serve = 0;
      case (m_mode)
         ST_IDLE, ST_OVER: if (st) begin
            m_mode = ST_SERVE; m_s1 = 0; m_s2 = 0; m_sec = 0; m_winner = 0;
            m_frames = 0; m_speed = SMIN; m_dir = 0; m_play_secs = 0; m_serve_cnt = 0;
         end
         ST_SERVE: if (tk) begin
            m_serve_cnt++;
            if (m_serve_cnt == SRV) begin
               m_serve_cnt = 0; m_mode = ST_PLAY; m_serve = 1;
            end
         end
         ST_PLAY: begin
            if (gl || gr) begin
               m_speed = SMIN; m_play_secs = 0; m_mode = ST_SERVE;
               if (gr && !gl) begin
                  m_s1++; m_dir = 1;
                  if (m_s1 == WIN) begin m_mode = ST_OVER; m_winner = 1; end
               end else if (gl && !gr) begin
                  m_s2++; m_dir = 0;
                  if (m_s2 == WIN) begin m_mode = ST_OVER; m_winner = 2; end
               end
            end else begin
               if (pa) m_mode = ST_PAUSE;
               if (tk) begin
                  m_frames++;
                  if (m_frames == FPS) begin
                     m_frames = 0;
                     if (m_sec < MAXS) m_sec++;
                     m_play_secs++;
                     if (m_play_secs == STEP) begin
                        m_play_secs = 0;
                        if (m_speed < SMAX) m_speed++;
                     end
                  end
               end
            end
         end
         ST_PAUSE: if (pa) m_mode = ST_PLAY;
         default: m_mode = ST_IDLE;
      endcase
      m_run = (m_mode == ST_PLAY) ? 1 : 0;
   endtask

   task automatic compare_model();
      check("state",      bus.state,         m_mode);
      check("run",        bus.run,           m_run);
      check("ball_serve", bus.ball_serve,    m_serve);
      check("serve_dir",  bus.serve_dir,     m_dir);
      check("score_p1",   bus.score_player1, m_s1);
      check("score_p2",   bus.score_player2, m_s2);
      check("seconds",    bus.seconds,       m_sec);
      check("ball_speed", bus.ball_speed,    m_speed);
      check("winner",     bus.winner,        m_winner);
   endtask

   task automatic step(input logic st, pa, gl, gr, tk);
      bus.start_pulse  = st;
      bus.pause_pulse  = pa;
      bus.goal_left    = gl;
      bus.goal_right   = gr;
      bus.refresh_tick = tk;
      @(posedge clk);
      #1;
      bus.start_pulse = 0; bus.pause_pulse = 0; bus.goal_left = 0;
      bus.goal_right = 0; bus.refresh_tick = 0;
      model_step(st, pa, gl, gr, tk);
      compare_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.start_pulse = 0; bus.pause_pulse = 0; bus.goal_left = 0;
      bus.goal_right = 0; bus.refresh_tick = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      compare_model();
   endtask

   typedef struct {
      logic st, pa, gl, gr, tk;
      logic [2:0] e_state;
      logic e_run, e_serve;
   } vec_t;
   vec_t vecs[10];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start_pulse = 0; bus.pause_pulse = 0; bus.goal_left = 0;
      bus.goal_right = 0; bus.refresh_tick = 0;
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,  1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_SERVE, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ST_SERVE, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ST_SERVE, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ST_PLAY,  1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_PLAY,  1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_PLAY,  1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ST_PAUSE, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_PAUSE, 1'b0, 1'b0};
      vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ST_PLAY,  1'b1, 1'b0};

      // 1: reset, start, serve delay, launch
      do_reset();
      check("rst_state", bus.state, ST_IDLE);
      check("rst_speed", bus.ball_speed, SMIN);
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].st, vecs[i].pa, vecs[i].gl, vecs[i].gr, vecs[i].tk);
         check($sformatf("vec%0d_state", i), bus.state, vecs[i].e_state);
         check($sformatf("vec%0d_run", i), bus.run, vecs[i].e_run);
         check($sformatf("vec%0d_serve", i), bus.ball_serve, vecs[i].e_serve);
      end

      // 2: match clock and speed ramp with saturation
      ticks(8);
      check("t2_sec2", bus.seconds, 2);
      check("t2_spd3", bus.ball_speed, 3);
      ticks(8);
      check("t2_sec4", bus.seconds, 4);
      check("t2_spd4", bus.ball_speed, 4);
      ticks(8);
      check("t2_sec6", bus.seconds, 6);
      check("t2_spd_sat", bus.ball_speed, 4);

      // 3: player1 wins 3:0
      for (int g = 1; g <= 3; g++) begin
         step(0, 0, 0, 1, 0);
         check("t3_score1", bus.score_player1, g);
         check("t3_dir", bus.serve_dir, 1);
         check("t3_speed", bus.ball_speed, SMIN);
         if (g < 3) ticks(SRV);
      end
      check("t3_state", bus.state, ST_OVER);
      check("t3_winner", bus.winner, WIN_P1);
      check("t3_run", bus.run, 0);
      step(0, 1, 0, 0, 1);
      check("t3_held", bus.state, ST_OVER);

      // 4: simultaneous goals, fresh match from OVER
      step(1, 0, 0, 0, 0);
      check("t4_fresh", bus.score_player1, 0);
      check("t4_winner", bus.winner, WIN_NONE);
      ticks(SRV);
      ticks(8);
      step(0, 0, 0, 1, 0);
      ticks(SRV);
      ticks(8);
      check("t4_spd_up", bus.ball_speed, 3);
      step(0, 0, 1, 1, 0);
      check("t4_state", bus.state, ST_SERVE);
      check("t4_s1", bus.score_player1, 1);
      check("t4_s2", bus.score_player2, 0);
      check("t4_dir", bus.serve_dir, 1);
      check("t4_speed", bus.ball_speed, SMIN);

      // goal and refresh_tick together: frame does not advance
      ticks(SRV);
      ticks(3);
      step(0, 0, 1, 0, 1);
      check("t4_goal_tick_sec", bus.seconds, 4);
      ticks(SRV);
      ticks(1);
      check("t4_after_sec", bus.seconds, 5);

      // 5: pause freezes counters and ignores goals
      step(0, 1, 0, 0, 0);
      check("t5_pause", bus.state, ST_PAUSE);
      check("t5_run", bus.run, 0);
      ticks(10);
      step(0, 0, 1, 0, 1);
      check("t5_sec_frozen", bus.seconds, 5);
      check("t5_s2_frozen", bus.score_player2, 1);
      step(0, 1, 0, 0, 0);
      check("t5_resume", bus.state, ST_PLAY);
      ticks(4);
      check("t5_sec_run", bus.seconds, 6);
      step(0, 1, 1, 0, 0);
      check("t5_goal_beats_pause", bus.state, ST_SERVE);
      check("t5_s2", bus.score_player2, 2);

      // 6: reset mid-play at 2:1
      do_reset();
      step(1, 0, 0, 0, 0);
      ticks(SRV);
      step(0, 0, 0, 1, 0); ticks(SRV);
      step(0, 0, 0, 1, 0); ticks(SRV);
      step(0, 0, 1, 0, 0); ticks(SRV);
      ticks(5);
      check("t6_s1", bus.score_player1, 2);
      check("t6_s2", bus.score_player2, 1);
      do_reset();
      check("t6_state", bus.state, ST_IDLE);
      check("t6_run", bus.run, 0);
      check("t6_scores", {bus.score_player1, bus.score_player2}, 0);
      check("t6_sec", bus.seconds, 0);
      check("t6_speed", bus.ball_speed, SMIN);
      check("t6_winner", bus.winner, 0);
      check("t6_dir", bus.serve_dir, 0);

      // seconds saturation
      step(1, 0, 0, 0, 0);
      ticks(SRV);
      ticks((MAXS + 3) * FPS);
      check("sat_sec", bus.seconds, MAXS);
      check("sat_speed", bus.ball_speed, SMAX);

      // random traffic against the reference model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(599) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(99) < 5, $urandom_range(99) < 4,
                 $urandom_range(99) < 3, $urandom_range(99) < 3,
                 $urandom_range(99) < 35);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
